// File: rtl/image_xfer_pkg.sv
// Shared types and elaboration helpers for the image transfer controller.
package image_xfer_pkg;

  typedef enum logic [6:0] {
    S_RECEIVE   = 7'b0000001,
    S_START     = 7'b0000010,
    S_PROCESS   = 7'b0000100,
    S_READ      = 7'b0001000,
    S_READ_WAIT = 7'b0010000,
    S_TRANSMIT  = 7'b0100000,
    S_DONE      = 7'b1000000
  } state_e;

  function automatic bit rd_latency_ok(input int lat);
    return (lat >= 1) && (lat <= 2);
  endfunction

  // Wide enough to hold N itself, so a full 2^ADDR_W job count is representable.
  function automatic int cnt_w(input longint n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/image_transfer_controller_if.sv
// UART, CPU and RAM-side signals of the image transfer controller.
interface image_transfer_controller_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic              RX_VALID;
  logic [DATA_W-1:0] RX_DATA;
  logic              TX_DONE;
  logic              TX_START;
  logic [DATA_W-1:0] TX_DATA;
  logic [ADDR_W-1:0] RAM_ADDRESS;
  logic [DATA_W-1:0] RAM_DATA;
  logic              RAM_WRITE_EN;
  logic [DATA_W-1:0] RAM_Q;
  logic              BUS_GRANT_CPU;
  logic              START_PROCESSING;
  logic              PROCESS_FINISHED;
  logic              JOB_DONE;
  logic              RX_OVERRUN;

  modport master (
    input  RX_VALID, RX_DATA, TX_DONE, RAM_Q, PROCESS_FINISHED,
    output TX_START, TX_DATA, RAM_ADDRESS, RAM_DATA, RAM_WRITE_EN,
           BUS_GRANT_CPU, START_PROCESSING, JOB_DONE, RX_OVERRUN
  );

  modport slave (
    output RX_VALID, RX_DATA, TX_DONE, RAM_Q, PROCESS_FINISHED,
    input  TX_START, TX_DATA, RAM_ADDRESS, RAM_DATA, RAM_WRITE_EN,
           BUS_GRANT_CPU, START_PROCESSING, JOB_DONE, RX_OVERRUN
  );
endinterface

// File: rtl/xfer_word_counter.sv
// Up-counter with clear and enable; tc flags that the current count is the last word.
module xfer_word_counter #(
  parameter int W    = 17,
  parameter int TERM = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_q, count_d;

  // Clear and enable together restart the count at one (first word already taken).
  always_comb begin
    count_d = (clr ? '0 : count_q) + W'(en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
  assign tc    = (count_q == W'(TERM - 1));

endmodule

// File: rtl/image_transfer_controller.sv
// Sequences receive -> CPU processing -> transmit around the shared image RAM.
module image_transfer_controller
  import image_xfer_pkg::*;
#(
  parameter int              DATA_W      = 8,
  parameter int              ADDR_W      = 16,
  parameter int              IMAGE_WORDS = 65536,
  parameter int              TX_WORDS    = 16384,
  parameter logic [ADDR_W-1:0] RX_BASE   = '0,
  parameter logic [ADDR_W-1:0] TX_BASE   = '0,
  parameter int              RD_LATENCY  = 1
) (
  input logic                  MAIN_CLOCK,
  input logic                  RESET_N,
  image_transfer_controller_if.master bus
);

  localparam int CNT_W = cnt_w(longint'(1) << ADDR_W);

  if (!rd_latency_ok(RD_LATENCY)) begin : g_lat_check
    $error("RD_LATENCY must be 1 or 2");
  end

  state_e                state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_W-1:0]     tx_data_q, tx_data_d;
  logic                  grant_q, grant_d;
  logic                  start_proc_q, start_proc_d;
  logic                  job_done_q, job_done_d;
  logic                  overrun_q, overrun_d;
  logic                  last_wr_q, last_wr_d;
  logic                  fin_prev_q, fin_prev_d;
  logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;

  logic             rx_clr, rx_en, rx_tc, tx_clr, tx_en, tx_tc;
  logic [CNT_W-1:0] rx_count, tx_count;

  xfer_word_counter #(.W(CNT_W), .TERM(IMAGE_WORDS)) u_rx_cnt (
    .clk(MAIN_CLOCK), .rst_n(RESET_N), .clr(rx_clr), .en(rx_en),
    .count(rx_count), .tc(rx_tc)
  );

  xfer_word_counter #(.W(CNT_W), .TERM(TX_WORDS)) u_tx_cnt (
    .clk(MAIN_CLOCK), .rst_n(RESET_N), .clr(tx_clr), .en(tx_en),
    .count(tx_count), .tc(tx_tc)
  );

  always_comb begin
    state_d      = state_q;
    wr_en_d      = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    grant_d      = grant_q;
    start_proc_d = 1'b0;
    job_done_d   = job_done_q;
    overrun_d    = overrun_q;
    last_wr_d    = 1'b0;
    fin_prev_d   = bus.PROCESS_FINISHED;
    rd_pipe_d    = RD_LATENCY'({rd_pipe_q, state_q == S_READ});
    rx_clr       = 1'b0;
    rx_en        = 1'b0;
    tx_clr       = 1'b0;
    tx_en        = 1'b0;

    // A word arriving while the final write is on the bus already belongs to no job.
    if (bus.RX_VALID && !(state_q == S_DONE || (state_q == S_RECEIVE && !last_wr_q)))
      overrun_d = 1'b1;

    case (state_q)
      S_RECEIVE: begin
        if (last_wr_q) begin
          state_d      = S_START;
          grant_d      = 1'b1;
          start_proc_d = 1'b1;
        end else if (bus.RX_VALID) begin
          wr_en_d   = 1'b1;
          addr_d    = RX_BASE + ADDR_W'(rx_count);
          wdata_d   = bus.RX_DATA;
          rx_en     = 1'b1;
          last_wr_d = rx_tc;
        end
      end
      S_START: state_d = S_PROCESS;
      S_PROCESS: begin
        if (bus.PROCESS_FINISHED && !fin_prev_q) begin
          grant_d = 1'b0;
          addr_d  = TX_BASE + ADDR_W'(tx_count);
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_READ_WAIT;
      S_READ_WAIT: begin
        if (rd_pipe_q[RD_LATENCY-1]) begin
          tx_data_d  = bus.RAM_Q;
          tx_start_d = 1'b1;
          state_d    = S_TRANSMIT;
        end
      end
      S_TRANSMIT: begin
        if (bus.TX_DONE) begin
          tx_en = 1'b1;
          if (tx_tc) begin
            job_done_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            addr_d  = TX_BASE + ADDR_W'(tx_count) + ADDR_W'(1);
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        if (bus.RX_VALID) begin
          job_done_d = 1'b0;
          rx_clr     = 1'b1;
          rx_en      = 1'b1;
          tx_clr     = 1'b1;
          wr_en_d    = 1'b1;
          addr_d     = RX_BASE;
          wdata_d    = bus.RX_DATA;
          last_wr_d  = (IMAGE_WORDS == 1);
          state_d    = S_RECEIVE;
        end
      end
      default: state_d = S_RECEIVE;
    endcase
  end

  always_ff @(posedge MAIN_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_RECEIVE;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      grant_q      <= 1'b0;
      start_proc_q <= 1'b0;
      job_done_q   <= 1'b0;
      overrun_q    <= 1'b0;
      last_wr_q    <= 1'b0;
      fin_prev_q   <= 1'b0;
      rd_pipe_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      grant_q      <= grant_d;
      start_proc_q <= start_proc_d;
      job_done_q   <= job_done_d;
      overrun_q    <= overrun_d;
      last_wr_q    <= last_wr_d;
      fin_prev_q   <= fin_prev_d;
      rd_pipe_q    <= rd_pipe_d;
    end
  end

  assign bus.TX_START         = tx_start_q;
  assign bus.TX_DATA          = tx_data_q;
  assign bus.RAM_ADDRESS      = addr_q;
  assign bus.RAM_DATA         = wdata_q;
  assign bus.RAM_WRITE_EN     = wr_en_q;
  assign bus.BUS_GRANT_CPU    = grant_q;
  assign bus.START_PROCESSING = start_proc_q;
  assign bus.JOB_DONE         = job_done_q;
  assign bus.RX_OVERRUN       = overrun_q;

endmodule

// File: tb/tb_image_transfer_controller.sv
// Directed bench with RAM/CPU model and write/transmit scoreboards.
module tb_image_transfer_controller;
  import image_xfer_pkg::*;

  localparam logic [15:0] RXB = 16'hFFFE;
  localparam logic [15:0] TXB = 16'h0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  image_transfer_controller_if #(.DATA_W(8), .ADDR_W(16)) bus ();

  image_transfer_controller #(
    .DATA_W(8), .ADDR_W(16), .IMAGE_WORDS(4), .TX_WORDS(3),
    .RX_BASE(RXB), .TX_BASE(TXB), .RD_LATENCY(2)
  ) dut (
    .MAIN_CLOCK(clk),
    .RESET_N(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // RAM with two-cycle read latency; CPU port used while the bus is granted.
  logic [7:0]  mem [0:65535];
  logic [7:0]  q1, q2;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_data = '0;

  always @(posedge clk) begin
    if (bus.BUS_GRANT_CPU) begin
      if (cpu_we) mem[cpu_addr] <= cpu_data;
    end else if (bus.RAM_WRITE_EN) begin
      mem[bus.RAM_ADDRESS] <= bus.RAM_DATA;
    end
    q1 <= mem[bus.RAM_ADDRESS];
    q2 <= q1;
  end
  assign bus.RAM_Q = q2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [23:0] wr_q [$];
  logic [7:0]  tx_q [$];
  logic [23:0] wr_e;
  logic [7:0]  tx_e;
  int n_start = 0;
  int n_txs   = 0;

  always @(negedge clk) begin
    if (bus.RAM_WRITE_EN) begin
      chk("wr_pending", 32'(wr_q.size() > 0), 1);
      if (wr_q.size() > 0) begin
        wr_e = wr_q.pop_front();
        chk("wr_addr", 32'(bus.RAM_ADDRESS), 32'(wr_e[23:8]));
        chk("wr_data", 32'(bus.RAM_DATA), 32'(wr_e[7:0]));
      end
    end
    if (bus.TX_START) begin
      n_txs++;
      chk("tx_pending", 32'(tx_q.size() > 0), 1);
      if (tx_q.size() > 0) begin
        tx_e = tx_q.pop_front();
        chk("tx_data", 32'(bus.TX_DATA), 32'(tx_e));
      end
    end
    if (bus.START_PROCESSING) n_start++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic [15:0] a);
    bus.RX_VALID = 1'b1;
    bus.RX_DATA  = b;
    wr_q.push_back({a, b});
    tick();
    bus.RX_VALID = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_we   = 1'b1;
    cpu_addr = a;
    cpu_data = d;
    tx_q.push_back(d);
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic wait_tx(output int cyc);
    cyc = 0;
    while (!bus.TX_START && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({bus.TX_START, bus.RAM_WRITE_EN, bus.BUS_GRANT_CPU,
                            bus.START_PROCESSING, bus.JOB_DONE, bus.RX_OVERRUN}), 0);
    chk({tag, "_data"}, {bus.TX_DATA, bus.RAM_ADDRESS, bus.RAM_DATA}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    bus.RX_VALID = 1'b0;
    bus.RX_DATA  = '0;
    bus.TX_DONE  = 1'b0;
    bus.PROCESS_FINISHED = 1'b0;

    tick(); tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Job 1: spaced words across the address wrap, finish level already high
    send_rx(8'h11, 16'hFFFE);
    chk("wr_latency", 32'(bus.RAM_WRITE_EN), 1);
    chk("grant_rx", 32'(bus.BUS_GRANT_CPU), 0);
    tick();
    chk("wr_one_cycle", 32'(bus.RAM_WRITE_EN), 0);
    tick();
    send_rx(8'h22, 16'hFFFF);
    tick();
    send_rx(8'h33, 16'h0000);
    bus.PROCESS_FINISHED = 1'b1;
    send_rx(8'h44, 16'h0001);
    tick();
    chk("start_pulse", 32'(bus.START_PROCESSING), 1);
    chk("start_grant", 32'(bus.BUS_GRANT_CPU), 1);
    chk("start_no_wr", 32'(bus.RAM_WRITE_EN), 0);
    tick();
    chk("start_one_cycle", 32'(bus.START_PROCESSING), 0);
    cpu_write(TXB + 16'd0, 8'hA0);
    cpu_write(TXB + 16'd1, 8'hA1);
    cpu_write(TXB + 16'd2, 8'hA2);
    chk("no_false_finish", 32'(bus.BUS_GRANT_CPU), 1);

    bus.RX_VALID = 1'b1;
    bus.RX_DATA  = 8'h99;
    tick();
    bus.RX_VALID = 1'b0;
    chk("overrun_dropped", 32'(bus.RAM_WRITE_EN), 0);
    chk("overrun_set", 32'(bus.RX_OVERRUN), 1);
    tick();
    chk("overrun_sticky", 32'(bus.RX_OVERRUN), 1);

    bus.PROCESS_FINISHED = 1'b0;
    tick(); tick();
    chk("still_process", 32'(bus.BUS_GRANT_CPU), 1);
    bus.PROCESS_FINISHED = 1'b1;
    tick();
    chk("finish_grant", 32'(bus.BUS_GRANT_CPU), 0);
    chk("finish_addr", 32'(bus.RAM_ADDRESS), 32'(TXB));

    for (int i = 0; i < 3; i++) begin
      wait_tx(c);
      chk("tx_latency", 32'(c), 3);
      tick(); tick();
      chk("tx_start_pulse", 32'(bus.TX_START), 0);
      chk("tx_hold", 32'(bus.TX_DATA), 32'(8'hA0 + 8'(i)));
      bus.TX_DONE = 1'b1;
      tick();
      bus.TX_DONE = 1'b0;
      if (i < 2) chk("next_addr", 32'(bus.RAM_ADDRESS), 32'(TXB + 16'(i + 1)));
      else       chk("job_done", 32'(bus.JOB_DONE), 1);
    end

    bus.TX_DONE = 1'b1;
    tick();
    bus.TX_DONE = 1'b0;
    tick();
    chk("done_ignores_txdone", 32'({bus.JOB_DONE, bus.TX_START}), 32'b10);
    chk("overrun_in_done", 32'(bus.RX_OVERRUN), 1);
    chk("start_count_1", 32'(n_start), 1);
    chk("tx_count_1", 32'(n_txs), 3);

    // Job 2: back-to-back words starting from DONE
    bus.PROCESS_FINISHED = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_rx(8'h55 + 8'(i * 17), RXB + 16'(i));
      chk("b2b_wr", 32'(bus.RAM_WRITE_EN), 1);
      if (i == 0) chk("job_done_clear", 32'(bus.JOB_DONE), 0);
    end
    tick();
    chk("start2_pulse", 32'(bus.START_PROCESSING), 1);
    tick();
    cpu_write(TXB + 16'd0, 8'hB0);
    cpu_write(TXB + 16'd1, 8'hB1);
    cpu_write(TXB + 16'd2, 8'hB2);
    bus.PROCESS_FINISHED = 1'b1;
    tick();
    chk("finish2_addr", 32'(bus.RAM_ADDRESS), 32'(TXB));
    wait_tx(c);
    chk("tx2_latency", 32'(c), 3);

    // Reset in the middle of TRANSMIT
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    tick(); tick();
    tx_q.delete();
    rst_n = 1'b1;
    tick();
    chk("post_rst_state", 32'(dut.state_q), 32'(S_RECEIVE));
    chk("post_rst_rxcnt", 32'(dut.u_rx_cnt.count_q), 0);
    chk("post_rst_txcnt", 32'(dut.u_tx_cnt.count_q), 0);
    chk_all_zero("post_rst");
    bus.PROCESS_FINISHED = 1'b0;
    send_rx(8'hC3, RXB);
    chk("post_rst_wr", 32'(bus.RAM_WRITE_EN), 1);
    tick();

    chk("wr_queue_empty", 32'(wr_q.size()), 0);
    chk("tx_queue_empty", 32'(tx_q.size()), 0);
    chk("start_count_2", 32'(n_start), 2);
    chk("tx_count_2", 32'(n_txs), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
